rvv_backend_xrf_wb_buffer: RTL and testbench
============================================

# rvv_backend_xrf_wb_buffer

Parametrised retire-to-XRF write-back buffer between the RVV retire stage and the scalar (RVS) integer register file. It accepts up to NUM_IN in-order scalar write-backs per cycle, stores them in a circular buffer of DEPTH entries, and drains up to NUM_OUT per cycle to the RVS XRF write ports. The retire stage therefore no longer stalls whenever RVS arbitration withholds ready for a cycle. It also reports occupancy and idle status for the backend idle logic.

## Interface
- NUM_IN, default `NUM_RT_UOP: number of retire-side write-back lanes.
- NUM_OUT, default 2: number of XRF write ports presented to RVS; 1..NUM_IN.
- DEPTH, default 8: number of buffer entries; power of two, ≥ NUM_IN.
- CNT_W, default $clog2(DEPTH+1): occupancy width. This is a derived parameter and is not overridden.
- clk  in  1  clock. The block uses this single clock.
- rst_n  in  1  asynchronous, active-low reset.
- rt_xrf_valid_rvv2rvs  in  NUM_IN  per-lane write-back valid.
- rt_xrf_rvv2rvs  in  NUM_IN×$bits(RT2XRF_t)  per-lane payload {rt_index, rt_data}.
- rt_xrf_ready_rvs2rvv  out  NUM_IN  per-lane accept.
- xrf_wb_valid  out  NUM_OUT  per-port write valid toward RVS.
- xrf_wb_data  out  NUM_OUT×$bits(RT2XRF_t)  per-port payload.
- xrf_wb_ready  in  NUM_OUT  per-port RVS grant.
- wb_cnt  out  CNT_W  current occupancy.
- wb_idle  out  1  high when the buffer is empty.

## Operation
- **Input ordering:** input valids must be a prefix, i.e. valid[i] implies valid[i-1]. A violation fires a simulation assertion; the RTL then behaves as prefix-truncated.
- **Input ready:** ready[i] = (DEPTH − wb_cnt) > i. It is computed from registered count only and has no combinational path from any input.
- **Push:** push_n = number of lanes i with valid[i] & ready[i]. Lane i is written to entry wr_ptr+i (mod DEPTH).
- **Output valid:** xrf_wb_valid[j] = wb_cnt > j. Port j presents entry rd_ptr+j.
- **Pop:** fire[j] = AND over k≤j of (valid[k] & ready[k]). pop_n = number of set fire bits.
  - A port that is valid and ready above a non-ready port does not fire.
  - Its entry re-presents next cycle on a lower port, in order.
- **Registered state updates:**
  - wr_ptr += push_n and rd_ptr += pop_n, both mod DEPTH (natural wrap; pointer width log2 DEPTH).
  - wb_cnt += push_n − pop_n, always within 0..DEPTH.
- **Ordering guarantees:**
  - Strict FIFO order end to end.
  - Same-rt_index writes are never reordered or merged.
- **Derived outputs:**
  - wb_idle = (wb_cnt == 0); this is a registered-state decode.
  - xrf_wb_data[j] for a non-valid port is don't-care; the implementation drives 0.

## Timing
- **Latency:** a write accepted in cycle N appears on an output port in cycle N+1 at the earliest. There is no input-to-output bypass.
- **Full buffer with simultaneous drain:** input ready reflects the start-of-cycle count, so a full buffer accepts nothing in the cycle it drains. The freed slots are offered one cycle later.
- **Empty buffer:** all xrf_wb_valid are low and wb_idle is high. Input ready is all ones as long as DEPTH ≥ NUM_IN.
- **Simultaneous push and pop:** both apply in the same edge. Count is updated by the net difference.
- **Reset values:** wr_ptr=0, rd_ptr=0, wb_cnt=0, wb_idle=1, xrf_wb_valid=0, rt_xrf_ready_rvs2rvv=all ones, xrf_wb_data=0.
- **Reset mid-operation:** reset asserting asynchronously discards all entries at once, and outputs reach their reset values without waiting for a clock edge. Storage RAM contents are not reset.

## Structure
- RT2XRF_t comes from the shared backend package header. NUM_RT_UOP and the new default XRF_WB_PORTS constant (2) live in the shared define header.
- Sub-module: multi_fifo, a generic N-push/M-pop circular buffer with pointers and count. This block wraps it and adds:
  - prefix/AND-chain handshake logic,
  - the idle decode,
  - assertions.
- Assertions:
  - input valid is a prefix,
  - wb_cnt ≤ DEPTH,
  - no output data X when valid.

## Test plan
- **Single write:** reset, then lane0 valid, rt_index=5, rt_data=0xDEADBEEF. Required response:
  - xrf_wb_valid=2'b01 next cycle, carrying that payload;
  - after xrf_wb_ready[0]=1, wb_cnt returns to 0 and wb_idle=1.
- **Fill to full:** DEPTH=8, NUM_IN=4, two cycles of 4 writes with xrf_wb_ready=0. Required response:
  - wb_cnt=8, input ready=4'b0000;
  - a third burst is not accepted.
- **Full with drain:** from full, assert xrf_wb_ready=2'b11 with 4 inputs valid. Required response:
  - pop 2 and push 0 in the first cycle; wb_cnt=6;
  - next cycle input ready=4'b0011; push 2 and pop 2; wb_cnt stays 6.
- **Gapped output ready:** 3 entries A,B,C buffered, xrf_wb_ready=2'b10. Required response:
  - no pop; wb_cnt stays 3;
  - next cycle with ready=2'b11, A and B drain, then C appears on port 0.
- **Wrap-around:** stream 20 writes with random prefix valids and random prefix readys. Required response: the output sequence equals the input sequence, checked by a scoreboard, across ≥2 pointer wraps.
- **Reset mid-operation:** assert rst_n low with 5 entries held. Required response:
  - xrf_wb_valid=0 and wb_cnt=0 immediately, before the next edge;
  - after release, the first new write appears with no stale data.

Source files
------------

// File: rtl/rvv_backend_xrf_wb_buffer_pkg.sv
// Shared backend types and defaults for the retire-to-XRF write-back path.
// RT2XRF_t is the per-lane scalar write-back payload.
package rvv_backend_xrf_wb_buffer_pkg;

    localparam int NUM_RT_UOP   = 4;
    localparam int XRF_WB_PORTS = 2;
    localparam int XLEN         = 32;
    localparam int XRF_IDX_W    = 5;

    typedef struct packed {
        logic [XRF_IDX_W-1:0] rt_index;
        logic [XLEN-1:0]      rt_data;
    } RT2XRF_t;

endpackage

// File: rtl/rvv_backend_xrf_wb_buffer_if.sv
// Retire-side and RVS-side handshake bundle of the XRF write-back buffer.
// The slave modport is the buffer; the master modport is its environment.
interface rvv_backend_xrf_wb_buffer_if
    import rvv_backend_xrf_wb_buffer_pkg::*;
#(
    parameter int NUM_IN  = NUM_RT_UOP,
    parameter int NUM_OUT = XRF_WB_PORTS,
    parameter int DEPTH   = 8
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic    [NUM_IN-1:0]  rt_xrf_valid_rvv2rvs;
    RT2XRF_t [NUM_IN-1:0]  rt_xrf_rvv2rvs;
    logic    [NUM_IN-1:0]  rt_xrf_ready_rvs2rvv;
    logic    [NUM_OUT-1:0] xrf_wb_valid;
    RT2XRF_t [NUM_OUT-1:0] xrf_wb_data;
    logic    [NUM_OUT-1:0] xrf_wb_ready;
    logic    [CNT_W-1:0]   wb_cnt;
    logic                  wb_idle;

    modport master (
        output rt_xrf_valid_rvv2rvs, rt_xrf_rvv2rvs, xrf_wb_ready,
        input  rt_xrf_ready_rvs2rvv, xrf_wb_valid, xrf_wb_data,
        input  wb_cnt, wb_idle
    );

    modport slave (
        input  rt_xrf_valid_rvv2rvs, rt_xrf_rvv2rvs, xrf_wb_ready,
        output rt_xrf_ready_rvs2rvv, xrf_wb_valid, xrf_wb_data,
        output wb_cnt, wb_idle
    );

endinterface

// File: rtl/rvv_backend_xrf_wb_buffer_multi_fifo.sv
// Generic N-push / M-pop circular buffer with registered pointers and count.
// Storage is not reset; only pointers and count are.
module multi_fifo
#(
    parameter int W       = 37,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int DEPTH   = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CNT_W-1:0]              i_push_n,
    input  logic [NUM_IN-1:0][W-1:0]      i_push_data,
    input  logic [CNT_W-1:0]              i_pop_n,
    output logic [NUM_OUT-1:0][W-1:0]     o_rd_data,
    output logic [CNT_W-1:0]              o_cnt
);
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_mem [DEPTH];

    // pointers wrap naturally at DEPTH; count moves by the net difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(i_push_n);
            r_rd_ptr <= r_rd_ptr + PW'(i_pop_n);
            r_cnt    <= r_cnt + i_push_n - i_pop_n;
        end
    end

    // lane i lands at wr_ptr+i for every accepted lane
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (CNT_W'(i) < i_push_n) begin
                r_mem[r_wr_ptr + PW'(i)] <= i_push_data[i];
            end
        end
    end

    // port j always looks at rd_ptr+j; validity is decided by the wrapper
    always_comb begin
        for (int j = 0; j < NUM_OUT; j++) begin
            o_rd_data[j] = r_mem[r_rd_ptr + PW'(j)];
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rvv_backend_xrf_wb_buffer.sv
// Retire-to-XRF write-back buffer: absorbs in-order scalar write-backs
// from retire and drains them to the RVS XRF ports in strict FIFO order.
module rvv_backend_xrf_wb_buffer
    import rvv_backend_xrf_wb_buffer_pkg::*;
#(
    parameter int NUM_IN  = NUM_RT_UOP,
    parameter int NUM_OUT = XRF_WB_PORTS,
    parameter int DEPTH   = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int W      = $bits(RT2XRF_t)
) (
    input logic                      clk,
    input logic                      rst_n,
    rvv_backend_xrf_wb_buffer_if.slave wb
);
    logic [CNT_W-1:0]             w_cnt;
    logic [CNT_W-1:0]             w_free;
    logic [CNT_W-1:0]             w_push_n;
    logic [CNT_W-1:0]             w_pop_n;
    logic [NUM_IN-1:0]            w_ready;
    logic [NUM_OUT-1:0]           w_valid;
    logic [NUM_OUT-1:0]           w_fire;
    logic                         w_in_run;
    logic                         w_out_run;
    logic [NUM_IN-1:0][W-1:0]     w_push_data;
    logic [NUM_OUT-1:0][W-1:0]    w_rd_data;

    // input ready from registered free space only; push counts the
    // leading run of accepted lanes, so a non-prefix valid is truncated
    always_comb begin
        w_free   = CNT_W'(DEPTH) - w_cnt;
        w_push_n = '0;
        w_in_run = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            w_ready[i]     = w_free > CNT_W'(i);
            w_in_run       = w_in_run & wb.rt_xrf_valid_rvv2rvs[i] & w_ready[i];
            w_push_data[i] = wb.rt_xrf_rvv2rvs[i];
            if (w_in_run) begin
                w_push_n = w_push_n + CNT_W'(1);
            end
        end
    end

    // a port fires only if every lower port fired too, keeping FIFO order
    always_comb begin
        w_pop_n   = '0;
        w_out_run = 1'b1;
        for (int j = 0; j < NUM_OUT; j++) begin
            w_valid[j] = w_cnt > CNT_W'(j);
            w_out_run  = w_out_run & w_valid[j] & wb.xrf_wb_ready[j];
            w_fire[j]  = w_out_run;
            if (w_out_run) begin
                w_pop_n = w_pop_n + CNT_W'(1);
            end
        end
    end

    multi_fifo #(
        .W       (W),
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push_n    (w_push_n),
        .i_push_data (w_push_data),
        .i_pop_n     (w_pop_n),
        .o_rd_data   (w_rd_data),
        .o_cnt       (w_cnt)
    );

    // non-valid ports drive zero so stale storage never leaks out
    always_comb begin
        for (int j = 0; j < NUM_OUT; j++) begin
            wb.xrf_wb_data[j] = w_valid[j] ? RT2XRF_t'(w_rd_data[j]) : '0;
        end
    end

    assign wb.rt_xrf_ready_rvs2rvv = w_ready;
    assign wb.xrf_wb_valid         = w_valid;
    assign wb.wb_cnt               = w_cnt;
    assign wb.wb_idle              = (w_cnt == '0);

    a_in_prefix: assert property (@(posedge clk) disable iff (!rst_n)
        ((wb.rt_xrf_valid_rvv2rvs >> 1) & ~wb.rt_xrf_valid_rvv2rvs) == '0);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_cnt <= CNT_W'(DEPTH));

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_xchk
        a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
            w_valid[g] |-> !$isunknown(wb.xrf_wb_data[g]));
    end

endmodule

// File: tb/tb_rvv_backend_xrf_wb_buffer.sv
// Self-checking bench for the XRF write-back buffer against a queue model.
// Directed scenarios followed by a randomized stream across pointer wraps.
module tb_rvv_backend_xrf_wb_buffer;
    import rvv_backend_xrf_wb_buffer_pkg::*;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int DP = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   n_pushed;
    RT2XRF_t q[$];

    rvv_backend_xrf_wb_buffer_if #(.NUM_IN(NI), .NUM_OUT(NO), .DEPTH(DP)) wb_if ();

    rvv_backend_xrf_wb_buffer #(.NUM_IN(NI), .NUM_OUT(NO), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NI-1:0] er;
        logic [NO-1:0] ev;
        for (int i = 0; i < NI; i++) er[i] = (DP - q.size()) > i;
        for (int j = 0; j < NO; j++) ev[j] = j < q.size();
        chk("cnt", 64'(wb_if.wb_cnt), 64'(q.size()));
        chk("idle", 64'(wb_if.wb_idle), 64'(q.size() == 0));
        chk("ready", 64'(wb_if.rt_xrf_ready_rvs2rvv), 64'(er));
        chk("valid", 64'(wb_if.xrf_wb_valid), 64'(ev));
        for (int j = 0; j < NO; j++)
            chk("data", 64'(wb_if.xrf_wb_data[j]), j < q.size() ? 64'(q[j]) : 64'd0);
    endtask

    function automatic RT2XRF_t rnd_payload();
        RT2XRF_t p;
        p.rt_index = 5'($urandom);
        p.rt_data  = $urandom;
        return p;
    endfunction

    // check, drive one cycle of inputs, advance the model, step the clock
    task automatic cycle(input logic [NI-1:0] vin, input RT2XRF_t [NI-1:0] din,
                         input logic [NO-1:0] rdy);
        int free;
        int pops;
        RT2XRF_t acc[$];
        check_outputs();
        wb_if.rt_xrf_valid_rvv2rvs = vin;
        wb_if.rt_xrf_rvv2rvs       = din;
        wb_if.xrf_wb_ready         = rdy;
        free = DP - q.size();
        pops = 0;
        for (int j = 0; j < NO; j++) begin
            if (j < q.size() && rdy[j]) pops++;
            else break;
        end
        for (int i = 0; i < NI; i++) begin
            if (vin[i] && i < free) acc.push_back(din[i]);
            else break;
        end
        repeat (pops) void'(q.pop_front());
        foreach (acc[k]) q.push_back(acc[k]);
        n_pushed += acc.size();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rnd_din(output RT2XRF_t [NI-1:0] d);
        for (int i = 0; i < NI; i++) d[i] = rnd_payload();
    endtask

    initial begin
        RT2XRF_t [NI-1:0] d;
        int cyc;
        n_chk = 0;
        n_err = 0;
        n_pushed = 0;
        rst_n = 1'b0;
        wb_if.rt_xrf_valid_rvv2rvs = '0;
        wb_if.rt_xrf_rvv2rvs       = '0;
        wb_if.xrf_wb_ready         = '0;
        repeat (2) @(negedge clk);
        check_outputs();
        chk("rst_data0", 64'(wb_if.xrf_wb_data[0]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write
        d = '0;
        d[0] = '{rt_index: 5'd5, rt_data: 32'hDEADBEEF};
        cycle(4'b0001, d, 2'b00);
        chk("single_valid", 64'(wb_if.xrf_wb_valid), 64'b01);
        chk("single_data", 64'(wb_if.xrf_wb_data[0]), {27'd0, 5'd5, 32'hDEADBEEF});
        cycle(4'b0000, d, 2'b01);
        chk("single_cnt", 64'(wb_if.wb_cnt), 64'd0);
        chk("single_idle", 64'(wb_if.wb_idle), 64'd1);

        // fill to full, third burst refused
        rnd_din(d); cycle(4'b1111, d, 2'b00);
        rnd_din(d); cycle(4'b1111, d, 2'b00);
        chk("full_cnt", 64'(wb_if.wb_cnt), 64'd8);
        chk("full_ready", 64'(wb_if.rt_xrf_ready_rvs2rvv), 64'd0);
        rnd_din(d); cycle(4'b1111, d, 2'b00);
        chk("full_burst3", 64'(wb_if.wb_cnt), 64'd8);

        // full with drain
        rnd_din(d); cycle(4'b1111, d, 2'b11);
        chk("drain_cnt1", 64'(wb_if.wb_cnt), 64'd6);
        chk("drain_ready", 64'(wb_if.rt_xrf_ready_rvs2rvv), 64'b0011);
        rnd_din(d); cycle(4'b1111, d, 2'b11);
        chk("drain_cnt2", 64'(wb_if.wb_cnt), 64'd6);

        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            cycle(4'b0000, d, 2'b11);
            cyc++;
        end
        chk("drain_empty", 64'(wb_if.wb_cnt), 64'd0);

        // gapped output ready
        rnd_din(d); cycle(4'b0111, d, 2'b00);
        chk("gap_cnt0", 64'(wb_if.wb_cnt), 64'd3);
        cycle(4'b0000, d, 2'b10);
        chk("gap_hold", 64'(wb_if.wb_cnt), 64'd3);
        cycle(4'b0000, d, 2'b11);
        chk("gap_cnt1", 64'(wb_if.wb_cnt), 64'd1);
        chk("gap_c_port0", 64'(wb_if.xrf_wb_data[0]), 64'(d[2]));
        cycle(4'b0000, d, 2'b01);

        // randomized stream across several pointer wraps
        n_pushed = 0;
        cyc = 0;
        while (n_pushed < 24 && cyc < 300) begin
            int nv;
            nv = $urandom_range(0, NI);
            rnd_din(d);
            cycle(4'((1 << nv) - 1), d, 2'($urandom));
            cyc++;
        end
        chk("wrap_done", 64'(n_pushed >= 24), 64'd1);
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            cycle(4'b0000, d, 2'b11);
            cyc++;
        end
        chk("wrap_empty", 64'(q.size()), 64'd0);

        // reset mid-operation with 5 entries held
        rnd_din(d); cycle(4'b1111, d, 2'b00);
        rnd_din(d); cycle(4'b0001, d, 2'b00);
        chk("pre_rst_cnt", 64'(wb_if.wb_cnt), 64'd5);
        wb_if.rt_xrf_valid_rvv2rvs = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(wb_if.xrf_wb_valid), 64'd0);
        chk("rst_cnt", 64'(wb_if.wb_cnt), 64'd0);
        chk("rst_idle", 64'(wb_if.wb_idle), 64'd1);
        chk("rst_ready", 64'(wb_if.rt_xrf_ready_rvs2rvv), 64'hF);
        chk("rst_data", 64'(wb_if.xrf_wb_data), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rnd_din(d); cycle(4'b0001, d, 2'b00);
        chk("post_rst_data", 64'(wb_if.xrf_wb_data[0]), 64'(d[0]));
        chk("post_rst_valid", 64'(wb_if.xrf_wb_valid), 64'b01);
        cycle(4'b0000, d, 2'b11);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
